multicycle_controller: RTL

//   Control unit for the multicycle MIPS datapath: Moore main FSM plus ALU decoder.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle MIPS datapath: Moore main FSM plus ALU decoder.
// Define MC_BNE_EN to add the BNEEX state (op 000101, branch on not-equal).
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrcA,
    output logic [1:0]         alusrcB,
    output logic [1:0]         pcsrc,
    output logic               jump,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPEEX  = 4'd6,
        RTYPEWB  = 4'd7,
        BEQEX    = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JEX      = 4'd11,
        BNEEX    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        iord         = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        regwrite_raw = 1'b0;
        alusrcA      = 1'b0;
        alusrcB      = 2'b00;
        pcsrc        = 2'b00;
        jump         = 1'b0;
        aluop        = 2'b00;
        case (state_q)
            FETCH: begin
                alusrcB     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                alusrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrcA = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BEQEX: begin
                alusrcA = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                alusrcA   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch    = 1'b1;
                branch_ne = 1'b1;
            end
`endif
            ADDIEX: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                jump    = 1'b1;
            end
            // Unused codes recover to FETCH with every enable held low.
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Write enables are gated by reset so an aborted instruction cannot commit.
    assign pcen     = ~reset & (pcwrite | (branch & (branch_ne ? ~zero : zero)));
    assign irwrite  = ~reset & irwrite_raw;
    assign regwrite = ~reset & regwrite_raw;
    assign memwrite = ~reset & memwrite_raw;
    assign state    = STATE_W'(state_q);

endmodule
